// File: rtl/input_from_aer_pkg.sv
// Shared field layout of the AER input word: {channel[23:20], timestamp[19:0]}.
// Latency: n/a (constants only).
// Backpressure: n/a.
package input_from_aer_pkg;

    localparam int CH_W_DEF   = 4;
    localparam int TS_W_DEF   = 20;
    localparam int NUM_CH_DEF = 16;
    localparam int WORD_W_DEF = CH_W_DEF + TS_W_DEF;

    // Bit positions of the fields inside the default 24-bit word.
    localparam int CH_MSB = 23;
    localparam int CH_LSB = 20;
    localparam int TS_MSB = 19;

endpackage

// File: rtl/input_from_aer_edge_detect.sv
// Registers the level-held AER valid and flags its low-to-high transition.
// Latency: rise_o is combinational from valid_i against the previous-cycle copy.
// Backpressure: none; the AER link cannot be stalled.
module input_from_aer_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic valid_i,
    output logic rise_o
);

    logic valid_q;

    // Previous-cycle copy of valid; reset low so valid held through reset counts as a new edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_i;
        end
    end

    assign rise_o = valid_i & ~valid_q;

endmodule

// File: rtl/input_from_aer.sv
// AER front end: splits {channel, timestamp} and emits one registered spike per valid rising edge.
// Latency: outputs update on the clock edge that first samples aer_valid high; spike pulse lasts 1 cycle.
// Backpressure: none; out-of-range channels consume the edge and are silently dropped.
module input_from_aer
    import input_from_aer_pkg::*;
#(
    parameter int CH_W   = CH_W_DEF,
    parameter int TS_W   = TS_W_DEF,
    parameter int NUM_CH = NUM_CH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CH_W+TS_W-1:0] in,
    input  logic                 aer_valid,
    output logic                 spike_detected,
    output logic [CH_W-1:0]      channel_Id,
    output logic [TS_W-1:0]      timestamp,
    output logic                 timestamp_valid
);

    logic [CH_W-1:0] ch_w;
    logic [TS_W-1:0] ts_w;
    logic            rise;
    logic            in_range;
    logic            accept;

    logic            spike_q, spike_d;
    logic [CH_W-1:0] ch_q, ch_d;
    logic [TS_W-1:0] ts_q, ts_d;
    logic            tv_q, tv_d;

    assign ch_w = in[TS_W +: CH_W];
    assign ts_w = in[TS_W-1:0];

    input_from_aer_edge_detect u_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (aer_valid),
        .rise_o  (rise)
    );

    // Zero-extend the channel so the range test works for any NUM_CH, including 2**CH_W.
    assign in_range = (32'(ch_w) < NUM_CH);
    assign accept   = rise & in_range;

    // Capture the word on an accepted edge; otherwise hold fields and drop the pulse.
    always_comb begin
        spike_d = 1'b0;
        ch_d    = ch_q;
        ts_d    = ts_q;
        tv_d    = tv_q;
        if (accept) begin
            spike_d = 1'b1;
            ch_d    = ch_w;
            ts_d    = ts_w;
            tv_d    = 1'b1;
        end
    end

    // Output registers, cleared immediately by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spike_q <= 1'b0;
            ch_q    <= '0;
            ts_q    <= '0;
            tv_q    <= 1'b0;
        end else begin
            spike_q <= spike_d;
            ch_q    <= ch_d;
            ts_q    <= ts_d;
            tv_q    <= tv_d;
        end
    end

    assign spike_detected  = spike_q;
    assign channel_Id      = ch_q;
    assign timestamp       = ts_q;
    assign timestamp_valid = tv_q;

endmodule

// File: tb/tb_input_from_aer.sv
// Bench for the AER front end: table-driven vectors plus a spike scoreboard on the 16-channel
// instance, and hand sequences for async mid-event reset and the 8-channel drop behaviour.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_input_from_aer;

    logic        clk;
    int          n_checks = 0;
    int          n_fail   = 0;

    // 16-channel instance
    logic        rst16_n, val16;
    logic [23:0] in16;
    logic        spk16, tv16;
    logic [3:0]  ch16;
    logic [19:0] ts16;

    // 8-channel instance
    logic        rst8_n, val8;
    logic [23:0] in8;
    logic        spk8, tv8;
    logic [3:0]  ch8;
    logic [19:0] ts8;

    input_from_aer #(.CH_W(4), .TS_W(20), .NUM_CH(16)) dut16 (
        .clk             (clk),
        .rst_n           (rst16_n),
        .in              (in16),
        .aer_valid       (val16),
        .spike_detected  (spk16),
        .channel_Id      (ch16),
        .timestamp       (ts16),
        .timestamp_valid (tv16)
    );

    input_from_aer #(.CH_W(4), .TS_W(20), .NUM_CH(8)) dut8 (
        .clk             (clk),
        .rst_n           (rst8_n),
        .in              (in8),
        .aer_valid       (val8),
        .spike_detected  (spk8),
        .channel_Id      (ch8),
        .timestamp       (ts8),
        .timestamp_valid (tv8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst_n;
        logic        vld;
        logic [23:0] word;
        int          reps;
        logic        spk;
        logic [3:0]  ch;
        logic [19:0] ts;
        logic        tv;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs[NV];

    logic [23:0] sb_q[$];
    logic        m_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out16(input string tag, input logic s, input logic [3:0] c,
                               input logic [19:0] t, input logic v);
        check({tag, ".spike"}, 32'(spk16), 32'(s));
        check({tag, ".chan"},  32'(ch16),  32'(c));
        check({tag, ".ts"},    32'(ts16),  32'(t));
        check({tag, ".tvld"},  32'(tv16),  32'(v));
    endtask

    // Drive dut16 for one cycle, feed the scoreboard, and match any produced spike.
    task automatic apply16(input logic r, input logic v, input logic [23:0] w);
        logic [23:0] exp_w;
        @(negedge clk);
        rst16_n = r;
        val16   = v;
        in16    = w;
        if (!r) m_prev = 1'b0;
        if (r && v && !m_prev) sb_q.push_back(w);
        @(posedge clk);
        #1;
        m_prev = r ? v : 1'b0;
        if (spk16) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: got spike ch=%0h ts=%0h required no spike", ch16, ts16);
            end else begin
                exp_w = sb_q.pop_front();
                check("sb_event", {8'h0, ch16, ts16}, {8'h0, exp_w});
            end
        end
        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_missing: got no spike required spike for %0h", sb_q[0]);
            sb_q.delete();
        end
    endtask

    task automatic apply8(input string tag, input logic r, input logic v, input logic [23:0] w,
                          input logic s, input logic [3:0] c, input logic [19:0] t, input logic tvx);
        @(negedge clk);
        rst8_n = r;
        val8   = v;
        in8    = w;
        @(posedge clk);
        #1;
        check({tag, ".spike"}, 32'(spk8), 32'(s));
        check({tag, ".chan"},  32'(ch8),  32'(c));
        check({tag, ".ts"},    32'(ts8),  32'(t));
        check({tag, ".tvld"},  32'(tv8),  32'(tvx));
    endtask

    initial begin
        rst16_n = 1'b0; val16 = 1'b0; in16 = '0;
        rst8_n  = 1'b0; val8  = 1'b0; in8  = '0;

        //          rst   vld   word         reps spk   ch     ts         tv
        vecs[0]  = '{1'b0, 1'b0, 24'h000000, 2, 1'b0, 4'h0, 20'h00000, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 24'h000000, 1, 1'b0, 4'h0, 20'h00000, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 24'hA12345, 1, 1'b1, 4'hA, 20'h12345, 1'b1};
        vecs[3]  = '{1'b1, 1'b1, 24'hA12345, 9, 1'b0, 4'hA, 20'h12345, 1'b1};
        vecs[4]  = '{1'b1, 1'b1, 24'hB00001, 2, 1'b0, 4'hA, 20'h12345, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 24'h000000, 2, 1'b0, 4'hA, 20'h12345, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 24'hA22245, 1, 1'b0, 4'h0, 20'h00000, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 24'hA22245, 1, 1'b1, 4'hA, 20'h22245, 1'b1};
        vecs[8]  = '{1'b1, 1'b1, 24'hA22245, 9, 1'b0, 4'hA, 20'h22245, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 24'h000000, 1, 1'b0, 4'hA, 20'h22245, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 24'h300001, 1, 1'b1, 4'h3, 20'h00001, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 24'h300001, 1, 1'b0, 4'h3, 20'h00001, 1'b1};
        vecs[12] = '{1'b1, 1'b1, 24'h5FFFFF, 1, 1'b1, 4'h5, 20'hFFFFF, 1'b1};
        vecs[13] = '{1'b1, 1'b0, 24'h000000, 1, 1'b0, 4'h5, 20'hFFFFF, 1'b1};
        vecs[14] = '{1'b1, 1'b1, 24'h000000, 1, 1'b1, 4'h0, 20'h00000, 1'b1};
        vecs[15] = '{1'b1, 1'b0, 24'h123456, 1, 1'b0, 4'h0, 20'h00000, 1'b1};
        vecs[16] = '{1'b1, 1'b1, 24'hF00ABC, 1, 1'b1, 4'hF, 20'h00ABC, 1'b1};
        vecs[17] = '{1'b1, 1'b1, 24'h1FFFFF, 3, 1'b0, 4'hF, 20'h00ABC, 1'b1};
        vecs[18] = '{1'b1, 1'b0, 24'h000000, 1, 1'b0, 4'hF, 20'h00ABC, 1'b1};

        for (int i = 0; i < NV; i++) begin
            for (int r = 0; r < vecs[i].reps; r++) begin
                apply16(vecs[i].rst_n, vecs[i].vld, vecs[i].word);
                check_out16($sformatf("vec%0d_%0d", i, r), vecs[i].spk, vecs[i].ch,
                            vecs[i].ts, vecs[i].tv);
            end
        end

        // Async reset in the middle of a held event clears outputs before any clock edge;
        // valid still high at release is a fresh rising edge.
        apply16(1'b1, 1'b1, 24'h4ABCDE);
        check_out16("pre_rst", 1'b1, 4'h4, 20'hABCDE, 1'b1);
        @(negedge clk);
        #2;
        rst16_n = 1'b0;
        m_prev  = 1'b0;
        #1;
        check_out16("async_rst", 1'b0, 4'h0, 20'h00000, 1'b0);
        apply16(1'b1, 1'b1, 24'h7ABCDE);
        check_out16("rst_release_edge", 1'b1, 4'h7, 20'hABCDE, 1'b1);
        apply16(1'b1, 1'b1, 24'h7ABCDE);
        check_out16("rst_release_hold", 1'b0, 4'h7, 20'hABCDE, 1'b1);
        apply16(1'b1, 1'b0, 24'h000000);

        // 8-channel instance: out-of-range channels are dropped and consume the edge.
        apply8("n8_rst",     1'b0, 1'b0, 24'h000000, 1'b0, 4'h0, 20'h00000, 1'b0);
        apply8("n8_ev",      1'b1, 1'b1, 24'h300007, 1'b1, 4'h3, 20'h00007, 1'b1);
        apply8("n8_low",     1'b1, 1'b0, 24'h000000, 1'b0, 4'h3, 20'h00007, 1'b1);
        apply8("n8_oor",     1'b1, 1'b1, 24'h900010, 1'b0, 4'h3, 20'h00007, 1'b1);
        apply8("n8_oor_hld", 1'b1, 1'b1, 24'h900010, 1'b0, 4'h3, 20'h00007, 1'b1);
        apply8("n8_noretry", 1'b1, 1'b1, 24'h200002, 1'b0, 4'h3, 20'h00007, 1'b1);
        apply8("n8_low2",    1'b1, 1'b0, 24'h000000, 1'b0, 4'h3, 20'h00007, 1'b1);
        apply8("n8_ch8",     1'b1, 1'b1, 24'h800000, 1'b0, 4'h3, 20'h00007, 1'b1);
        apply8("n8_low3",    1'b1, 1'b0, 24'h000000, 1'b0, 4'h3, 20'h00007, 1'b1);
        apply8("n8_ch7",     1'b1, 1'b1, 24'h700001, 1'b1, 4'h7, 20'h00001, 1'b1);
        apply8("n8_end",     1'b1, 1'b0, 24'h000000, 1'b0, 4'h7, 20'h00001, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
